fifo_write_ctrl: RTL and testbench

//  Write-side controller for the synchronous FIFO: owns the write pointer, derives level/full/almost-full

---
 rtl/fifo_write_ctrl.sv | 133 +++++++++++++
 tb/tb_fifo_write_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: FIFO write pointer, level/full/almost-full and burst reservation.
// Defining CFG_WR_ERR_CNT_EN adds o_wr_err_cnt, a saturating count of overflow-event cycles.
`ifndef CFG_FIFO_DEPTH
`define CFG_FIFO_DEPTH 16
`endif
module fifo_write_ctrl #(
    parameter int MEM_DEPTH    = `CFG_FIFO_DEPTH,
    parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH),
    parameter int AFULL_THRESH = MEM_DEPTH - 4,
    parameter int MAX_BURST    = 8,
    parameter int LEN_W        = $clog2(MAX_BURST + 1)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wr_valid,
    input  logic                i_wr_burst_start,
    input  logic [LEN_W-1:0]    i_wr_burst_len,
    input  logic [ADDR_WIDTH:0] i_rd_addr,
    input  logic                i_wr_ovf_clr,
    output logic                o_wr_ready,
    output logic                o_wr_en,
    output logic [ADDR_WIDTH:0] o_wr_addr,
    output logic [ADDR_WIDTH:0] o_wr_level,
    output logic                o_wr_full,
    output logic                o_wr_afull,
    output logic                o_burst_busy,
    output logic                o_burst_grant,
    output logic                o_burst_reject,
`ifdef CFG_WR_ERR_CNT_EN
    output logic [15:0]         o_wr_err_cnt,
`endif
    output logic                o_wr_overflow
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(MEM_DEPTH);
    localparam logic [PW-1:0] AFULL_P = PW'(AFULL_THRESH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           r_state;
    logic [PW-1:0]    r_wr_addr;
    logic [LEN_W-1:0] r_beats_left;
    logic             r_grant;
    logic             r_reject;
    logic             r_overflow;

    logic [PW-1:0]    w_level;
    logic [PW-1:0]    w_free;
    logic             w_full;
    logic             w_idle_req;
    logic             w_len_ok;
    logic             w_ready;
    logic             w_wr_en;
    logic             w_ovf_event;

    // Pointers carry a wrap bit, so plain subtraction gives 0..MEM_DEPTH.
    assign w_level    = r_wr_addr - i_rd_addr;
    assign w_free     = DEPTH_P - w_level;
    assign w_full     = w_level == DEPTH_P;
    assign w_idle_req = r_state == IDLE && i_wr_burst_start;
    assign w_len_ok   = i_wr_burst_len != '0
                     && 32'(i_wr_burst_len) <= 32'(MAX_BURST)
                     && 32'(i_wr_burst_len) <= 32'(w_free);

    // Inside a burst the space is already reserved and reads can only add more.
    assign w_ready     = !i_reset && (r_state == BURST || (!i_wr_burst_start && !w_full));
    assign w_wr_en     = i_wr_valid && w_ready;
    assign w_ovf_event = i_wr_valid && !w_ready && !w_idle_req;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_wr_addr    <= '0;
            r_beats_left <= '0;
            r_grant      <= 1'b0;
            r_reject     <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_grant    <= 1'b0;
            r_reject   <= 1'b0;
            r_overflow <= w_ovf_event || (r_overflow && !i_wr_ovf_clr);
            if (w_wr_en)
                r_wr_addr <= r_wr_addr + PW'(1);
            case (r_state)
                IDLE: begin
                    if (i_wr_burst_start) begin
                        if (w_len_ok) begin
                            r_state      <= BURST;
                            r_beats_left <= i_wr_burst_len;
                            r_grant      <= 1'b1;
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (w_wr_en) begin
                        r_beats_left <= r_beats_left - LEN_W'(1);
                        if (r_beats_left == LEN_W'(1))
                            r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CFG_WR_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_err_cnt <= '0;
        else if (i_wr_ovf_clr)
            r_err_cnt <= {15'd0, w_ovf_event};
        else if (w_ovf_event && r_err_cnt != 16'hFFFF)
            r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign o_wr_err_cnt = r_err_cnt;
`endif

    assign o_wr_ready     = w_ready;
    assign o_wr_en        = w_wr_en;
    assign o_wr_addr      = r_wr_addr;
    assign o_wr_level     = w_level;
    assign o_wr_full      = w_full;
    assign o_wr_afull     = w_level >= AFULL_P;
    assign o_burst_busy   = r_state == BURST;
    assign o_burst_grant  = r_grant;
    assign o_burst_reject = r_reject;
    assign o_wr_overflow  = r_overflow;
endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb_fifo_write_ctrl: vector tables, directed corner sequences and random traffic vs. a pointer-arithmetic model.
module tb_fifo_write_ctrl;
    localparam int DEPTH = 16;
    localparam int AFT   = 12;
    localparam int MB    = 8;
    localparam int PW    = 5;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid = 1'b0;
    logic          start = 1'b0;
    logic          clr = 1'b0;
    logic [LW-1:0] len = '0;
    logic [PW-1:0] rd = '0;
    logic          ready, en, full, afull, busy, grant, reject, ovf;
    logic [PW-1:0] addr, level;
`ifdef CFG_WR_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: total writes mod 32, reserved beats left (0 = no burst), registered flags.
    int m_addr, m_beats, m_cnt, m_rd;
    bit m_grant, m_reject, m_ovf;

    always #5 clk = ~clk;

    fifo_write_ctrl #(.MEM_DEPTH(DEPTH), .AFULL_THRESH(AFT), .MAX_BURST(MB)) dut (
        .i_clk(clk), .i_reset(reset), .i_wr_valid(valid), .i_wr_burst_start(start),
        .i_wr_burst_len(len), .i_rd_addr(rd), .i_wr_ovf_clr(clr),
        .o_wr_ready(ready), .o_wr_en(en), .o_wr_addr(addr), .o_wr_level(level),
        .o_wr_full(full), .o_wr_afull(afull), .o_burst_busy(busy),
        .o_burst_grant(grant), .o_burst_reject(reject),
`ifdef CFG_WR_ERR_CNT_EN
        .o_wr_err_cnt(err_cnt),
`endif
        .o_wr_overflow(ovf)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input bit v);
        @(negedge clk);
        reset = 1'b1; valid = v; start = 1'b0; clr = 1'b0;
        #1;
        chk("reset_no_wr_en", en, 0);
        m_addr = 0; m_beats = 0; m_cnt = 0; m_grant = 0; m_reject = 0; m_ovf = 0;
    endtask

    task automatic cyc(input bit v, input bit s, input int l, input int r, input bit c);
        int lvl;
        bit bz, rdy, e, ev;
        @(negedge clk);
        reset = 1'b0; valid = v; start = s; len = LW'(l); rd = PW'(r); clr = c;
        #1;
        lvl = (m_addr - r) & 31;
        bz  = m_beats > 0;
        rdy = bz || (!s && lvl != DEPTH);
        e   = v && rdy;
        ev  = v && !rdy && !(!bz && s);
        chk("wr_ready", ready, rdy);
        chk("wr_en", en, e);
        chk("wr_addr", addr, m_addr);
        chk("wr_level", level, lvl);
        chk("wr_full", full, lvl == DEPTH);
        chk("wr_afull", afull, lvl >= AFT);
        chk("burst_busy", busy, bz);
        chk("burst_grant", grant, m_grant);
        chk("burst_reject", reject, m_reject);
        chk("wr_overflow", ovf, m_ovf);
`ifdef CFG_WR_ERR_CNT_EN
        chk("wr_err_cnt", err_cnt, m_cnt);
`endif
        m_grant = 0; m_reject = 0;
        if (!bz && s) begin
            if (l >= 1 && l <= MB && DEPTH - lvl >= l) begin
                m_beats = l; m_grant = 1;
            end else begin
                m_reject = 1;
            end
        end else if (bz && e) begin
            m_beats--;
        end
        m_addr = (m_addr + int'(e)) % 32;
        m_cnt  = c ? int'(ev) : (ev && m_cnt < 65535 ? m_cnt + 1 : m_cnt);
        m_ovf  = ev || (m_ovf && !c);
    endtask

    typedef struct {
        int addr; int lvl; bit en; bit full; bit afull;
    } fill_vec_t;

    typedef struct {
        int lvl; int len; bit grant;
    } burst_vec_t;

    fill_vec_t  fv[17];
    burst_vec_t bv[8];

    initial begin
        int  r, lv;
        bit  saw_wrap;
        for (int i = 0; i < 17; i++) begin
            fv[i].addr  = i;
            fv[i].lvl   = i;
            fv[i].en    = i < DEPTH;
            fv[i].full  = i == DEPTH;
            fv[i].afull = i >= AFT;
        end
        bv[0] = '{10, 6, 1};
        bv[1] = '{11, 6, 0};
        bv[2] = '{11, 0, 0};
        bv[3] = '{11, 9, 0};
        bv[4] = '{8, 8, 1};
        bv[5] = '{9, 8, 0};
        bv[6] = '{15, 1, 1};
        bv[7] = '{16, 1, 0};

        // Fill from empty: 17 back-to-back writes, last one refused.
        do_reset(1'b1);
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, 1'b0, 0, 0, 1'b0);
            chk("fill_addr", addr, fv[i].addr);
            chk("fill_level", level, fv[i].lvl);
            chk("fill_en", en, fv[i].en);
            chk("fill_full", full, fv[i].full);
            chk("fill_afull", afull, fv[i].afull);
        end
        cyc(1'b0, 1'b0, 0, 0, 1'b0);
        chk("fill_overflow", ovf, 1);

        // Streaming with the reader three entries behind, across the pointer wrap.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 0, 0, 1'b0);
        saw_wrap = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_addr == 31) saw_wrap = 1;
            cyc(1'b1, 1'b0, 0, (m_addr - 3) & 31, 1'b0);
            chk("stream_level", level, 3);
            chk("stream_full", full, 0);
        end
        cyc(1'b0, 1'b0, 0, (m_addr - 3) & 31, 1'b0);
        chk("stream_wrapped", saw_wrap, 1);
        chk("stream_addr", addr, 43 % 32);

        // Burst reservation table; granted bursts are streamed with random gaps.
        for (int k = 0; k < 8; k++) begin
            r = (m_addr - bv[k].lvl) & 31;
            cyc(1'b0, 1'b1, bv[k].len, r, 1'b0);
            chk("req_no_wr_ready", ready, 0);
            lv = m_addr;
            cyc(1'b0, 1'b0, 0, r, 1'b0);
            chk("burst_grant_tbl", grant, bv[k].grant);
            chk("burst_reject_tbl", reject, !bv[k].grant);
            chk("burst_busy_tbl", busy, bv[k].grant);
            chk("burst_addr_hold", addr, lv);
            if (bv[k].grant) begin
                for (int b = 0; b < bv[k].len; b++) begin
                    while ($urandom_range(0, 1) == 1)
                        cyc(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 9), r, 1'b0);
                    cyc(1'b1, 1'b0, 0, r, 1'b0);
                end
                cyc(1'b0, 1'b0, 0, r, 1'b0);
                chk("burst_done_busy", busy, 0);
                chk("burst_done_full", full, bv[k].lvl + bv[k].len == DEPTH);
            end
        end

        // Reset three beats into an eight-beat burst.
        do_reset(1'b0);
        cyc(1'b0, 1'b1, 8, 0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 0, 0, 1'b0);
        chk("midburst_busy", busy, 1);
        do_reset(1'b1);
        cyc(1'b1, 1'b0, 0, 0, 1'b0);
        chk("post_reset_addr", addr, 0);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_en", en, 1);
        cyc(1'b0, 1'b0, 0, 0, 1'b0);
        chk("post_reset_next", addr, 1);

        // Overflow while full with a concurrent clear.
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 1'b1);
        cyc(1'b1, 1'b0, 0, 0, 1'b1);
        cyc(1'b0, 1'b0, 0, 0, 1'b0);
        chk("ovf_clr_race", ovf, 1);
`ifdef CFG_WR_ERR_CNT_EN
        chk("err_cnt_race", err_cnt, 1);
`endif
        cyc(1'b0, 1'b0, 0, 0, 1'b1);
        cyc(1'b0, 1'b0, 0, 0, 1'b0);
        chk("ovf_cleared", ovf, 0);

        // Random traffic with a reader that only moves forward.
        do_reset(1'b0);
        m_rd = 0;
        for (int i = 0; i < 3000; i++) begin
            lv = (m_addr - m_rd) & 31;
            if (lv > 0 && $urandom_range(0, 2) == 0) m_rd = (m_rd + 1) % 32;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9),
                m_rd, $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
